jzjpcc_memory_stage: RTL and testbench

Memory stage of the jzjpcc 5-stage pipeline, directly downstream of execute. It takes the execute→memory pipeline register contents and runs loads and stores on the data-memory bus. The bus uses a req/ack handshake with variable latency. The stage stalls the front of the pipeline while an access is pending, extracts and extends load data, and registers the results into the writeback stage.

---
 rtl/jzjpcc_memory_stage.sv | 158 +++++++++++++++
 tb/tb_jzjpcc_memory_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_memory_stage.sv
// jzjpcc memory stage: data bus access, load extension and MEM/WB register.
// Optional JZJPCC_MEM_MISALIGN_CHECK_EN faults misaligned half/word access.
module jzjpcc_memory_stage #(
  parameter int BUS_TIMEOUT = 255,
  parameter int PC_MAX_B = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_memory,
  input  logic [31:0] aluResult_memory,
  input  logic [31:0] memDataToWrite_memory,
  input  logic [3:0]  memByteMask_memory,
  input  logic        memoryWriteEnable_memory,
  input  logic        rdSource_memory,
  input  logic        rdWriteEnable_memory,
  input  logic [4:0]  rdAddr_memory,
  input  logic [2:0]  funct3_memory,
  output logic        dmemReq,
  output logic        dmemWrite,
  output logic [29:0] dmemAddr,
  output logic [31:0] dmemWriteData,
  output logic [3:0]  dmemByteMask,
  input  logic [31:0] dmemReadData,
  input  logic        dmemAck,
  output logic        stall_memory,
  output logic        busError,
  output logic        valid_writeback,
  output logic [4:0]  rdAddr_writeback,
  output logic        rdSource_writeback,
  output logic        rdWriteEnable_writeback,
  output logic [31:0] aluResult_writeback,
  output logic [31:0] memoryOut_writeback,
  output logic        misalignedFault
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [15:0] LAST = 16'(BUS_TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] count, count_next;
  logic [1:0]  off;
  logic        access, is_load, misaligned, go;
  logic        timed_out, abort, fault, hold, load_done;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  logic        unused_pc;

  assign unused_pc = (PC_MAX_B < 0);

  assign off     = aluResult_memory[1:0];
  assign access  = valid_memory &
                   (memoryWriteEnable_memory | rdSource_memory);
  assign is_load = rdSource_memory & ~memoryWriteEnable_memory;

`ifdef JZJPCC_MEM_MISALIGN_CHECK_EN
  assign misaligned =
    ((funct3_memory[1:0] == 2'b01) & off[0]) |
    ((funct3_memory[1:0] == 2'b10) & (off != 2'b00));
  assign fault = access & misaligned & ~reset;
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  assign misalignedFault = fault;
  assign go = access & ~misaligned;

  assign timed_out = (BUS_TIMEOUT != 0) && (state == WAIT) &&
                     (count == LAST);
  assign abort = go & ~dmemAck & timed_out & ~reset;

  assign dmemReq       = go & ~reset;
  assign dmemWrite     = memoryWriteEnable_memory;
  assign dmemAddr      = aluResult_memory[31:2];
  assign dmemWriteData = memDataToWrite_memory;
  assign dmemByteMask  = memoryWriteEnable_memory ?
                         memByteMask_memory : 4'hF;

  assign stall_memory = go & ~dmemAck & ~abort;
  assign busError     = abort;
  assign hold         = stall_memory | abort | fault;
  assign load_done    = go & dmemAck & is_load;

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (go && !dmemAck) begin
          state_next = WAIT;
          count_next = '0;
        end
      end
      WAIT: begin
        if (!go || dmemAck || abort) state_next = IDLE;
        else count_next = count + 16'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Little-endian lane select within the returned word
  always_comb begin
    byte_v = 8'h00;
    unique case (off)
      2'd0: byte_v = dmemReadData[7:0];
      2'd1: byte_v = dmemReadData[15:8];
      2'd2: byte_v = dmemReadData[23:16];
      2'd3: byte_v = dmemReadData[31:24];
      default: byte_v = 8'h00;
    endcase
  end

  assign half_v = off[1] ? dmemReadData[31:16] : dmemReadData[15:0];

  always_comb begin
    load_data = '0;
    case (funct3_memory)
      3'b000: load_data = {{24{byte_v[7]}}, byte_v};
      3'b100: load_data = {24'h0, byte_v};
      3'b001: load_data = {{16{half_v[15]}}, half_v};
      3'b101: load_data = {16'h0, half_v};
      3'b010: load_data = dmemReadData;
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_writeback         <= 1'b0;
      rdWriteEnable_writeback <= 1'b0;
      rdAddr_writeback        <= '0;
      rdSource_writeback      <= 1'b0;
      aluResult_writeback     <= '0;
      memoryOut_writeback     <= '0;
    end else begin
      valid_writeback         <= valid_memory & ~hold;
      rdWriteEnable_writeback <= rdWriteEnable_memory & ~hold;
      rdAddr_writeback        <= rdAddr_memory;
      rdSource_writeback      <= rdSource_memory;
      aluResult_writeback     <= aluResult_memory;
      if (load_done) memoryOut_writeback <= load_data;
    end
  end

endmodule

// File: tb/tb_jzjpcc_memory_stage.sv
// Directed bench for jzjpcc_memory_stage (built with BUS_TIMEOUT = 4).
// Each task drives one scenario and checks its own expected values.
module tb_jzjpcc_memory_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_memory;
  logic [31:0] aluResult_memory;
  logic [31:0] memDataToWrite_memory;
  logic [3:0]  memByteMask_memory;
  logic        memoryWriteEnable_memory;
  logic        rdSource_memory;
  logic        rdWriteEnable_memory;
  logic [4:0]  rdAddr_memory;
  logic [2:0]  funct3_memory;
  logic        dmemReq;
  logic        dmemWrite;
  logic [29:0] dmemAddr;
  logic [31:0] dmemWriteData;
  logic [3:0]  dmemByteMask;
  logic [31:0] dmemReadData;
  logic        dmemAck;
  logic        stall_memory;
  logic        busError;
  logic        valid_writeback;
  logic [4:0]  rdAddr_writeback;
  logic        rdSource_writeback;
  logic        rdWriteEnable_writeback;
  logic [31:0] aluResult_writeback;
  logic [31:0] memoryOut_writeback;
  logic        misalignedFault;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  jzjpcc_memory_stage #(.BUS_TIMEOUT(4)) dut (
    .clock(clock),
    .reset(reset),
    .valid_memory(valid_memory),
    .aluResult_memory(aluResult_memory),
    .memDataToWrite_memory(memDataToWrite_memory),
    .memByteMask_memory(memByteMask_memory),
    .memoryWriteEnable_memory(memoryWriteEnable_memory),
    .rdSource_memory(rdSource_memory),
    .rdWriteEnable_memory(rdWriteEnable_memory),
    .rdAddr_memory(rdAddr_memory),
    .funct3_memory(funct3_memory),
    .dmemReq(dmemReq),
    .dmemWrite(dmemWrite),
    .dmemAddr(dmemAddr),
    .dmemWriteData(dmemWriteData),
    .dmemByteMask(dmemByteMask),
    .dmemReadData(dmemReadData),
    .dmemAck(dmemAck),
    .stall_memory(stall_memory),
    .busError(busError),
    .valid_writeback(valid_writeback),
    .rdAddr_writeback(rdAddr_writeback),
    .rdSource_writeback(rdSource_writeback),
    .rdWriteEnable_writeback(rdWriteEnable_writeback),
    .aluResult_writeback(aluResult_writeback),
    .memoryOut_writeback(memoryOut_writeback),
    .misalignedFault(misalignedFault)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    valid_memory = 1'b0;
    aluResult_memory = '0;
    memDataToWrite_memory = '0;
    memByteMask_memory = '0;
    memoryWriteEnable_memory = 1'b0;
    rdSource_memory = 1'b0;
    rdWriteEnable_memory = 1'b0;
    rdAddr_memory = '0;
    funct3_memory = '0;
    dmemReadData = '0;
    dmemAck = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f,
                      input logic [4:0] r);
    valid_memory = 1'b1;
    memoryWriteEnable_memory = 1'b0;
    rdSource_memory = 1'b1;
    rdWriteEnable_memory = 1'b1;
    aluResult_memory = a;
    funct3_memory = f;
    rdAddr_memory = r;
  endtask

  task automatic test_lw();
    load(32'h0000_0104, 3'b010, 5'd5);
    dmemAck = 1'b1;
    dmemReadData = 32'hDEAD_BEEF;
    #1;
    tests++; if (stall_memory !== 1'b0) begin fails++; $display("FAIL lw_stall got %b want 0", stall_memory); end
    tests++; if (dmemReq !== 1'b1) begin fails++; $display("FAIL lw_req got %b want 1", dmemReq); end
    tests++; if (dmemAddr !== 30'h41) begin fails++; $display("FAIL lw_addr got %h want 41", dmemAddr); end
    tests++; if (dmemWrite !== 1'b0) begin fails++; $display("FAIL lw_write got %b want 0", dmemWrite); end
    tests++; if (dmemByteMask !== 4'hF) begin fails++; $display("FAIL lw_mask got %h want f", dmemByteMask); end
    tick();
    idle_in();
    tests++; if (memoryOut_writeback !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_data got %h want deadbeef", memoryOut_writeback); end
    tests++; if (valid_writeback !== 1'b1) begin fails++; $display("FAIL lw_valid got %b want 1", valid_writeback); end
    tests++; if (rdWriteEnable_writeback !== 1'b1) begin fails++; $display("FAIL lw_rdwe got %b want 1", rdWriteEnable_writeback); end
    tests++; if (rdAddr_writeback !== 5'd5) begin fails++; $display("FAIL lw_rd got %0d want 5", rdAddr_writeback); end
    tests++; if (rdSource_writeback !== 1'b1) begin fails++; $display("FAIL lw_src got %b want 1", rdSource_writeback); end
  endtask

  task automatic test_reset();
    load(32'h0000_0300, 3'b010, 5'd9);
    dmemAck = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    tests++; if (dmemReq !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", dmemReq); end
    tests++; if (busError !== 1'b0) begin fails++; $display("FAIL rst_buserr got %b want 0", busError); end
    tick();
    tests++; if (valid_writeback !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", valid_writeback); end
    tests++; if (rdWriteEnable_writeback !== 1'b0) begin fails++; $display("FAIL rst_rdwe got %b want 0", rdWriteEnable_writeback); end
    tests++; if (rdAddr_writeback !== 5'd0) begin fails++; $display("FAIL rst_rd got %0d want 0", rdAddr_writeback); end
    tests++; if (rdSource_writeback !== 1'b0) begin fails++; $display("FAIL rst_src got %b want 0", rdSource_writeback); end
    tests++; if (aluResult_writeback !== 32'h0) begin fails++; $display("FAIL rst_alu got %h want 0", aluResult_writeback); end
    tests++; if (memoryOut_writeback !== 32'h0) begin fails++; $display("FAIL rst_mem got %h want 0", memoryOut_writeback); end
    #1;
    tests++; if (dmemReq !== 1'b0) begin fails++; $display("FAIL rst_req2 got %b want 0", dmemReq); end
    tick();
    reset = 1'b0;
    // A fresh wait must see the full timeout window from IDLE
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (stall_memory !== 1'b1 || busError !== 1'b0) begin fails++; $display("FAIL rst_restart%0d got stall=%b err=%b want stall=1 err=0", i, stall_memory, busError); end
      tick();
    end
    dmemAck = 1'b1;
    dmemReadData = 32'h0BAD_F00D;
    tick();
    idle_in();
    tests++; if (valid_writeback !== 1'b1 || memoryOut_writeback !== 32'h0BAD_F00D) begin fails++; $display("FAIL rst_after got v=%b d=%h want v=1 d=0badf00d", valid_writeback, memoryOut_writeback); end
  endtask

  task automatic test_load_ext();
    logic [31:0] adr [8];
    logic [2:0]  f3  [8];
    logic [31:0] dat [8];
    logic [31:0] exp [8];
    adr = '{32'h203, 32'h203, 32'h200, 32'h202,
            32'h202, 32'h200, 32'h201, 32'h200};
    f3  = '{3'b000, 3'b100, 3'b000, 3'b001,
            3'b101, 3'b001, 3'b100, 3'b011};
    dat = '{32'h80FF_FF7F, 32'h80FF_FF7F, 32'h80FF_FF7F, 32'h80FF_FF7F,
            32'h80FF_FF7F, 32'h1234_8001, 32'h1234_5678, 32'hFFFF_FFFF};
    exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_80FF,
            32'h0000_80FF, 32'hFFFF_8001, 32'h0000_0056, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      load(adr[i], f3[i], 5'd3);
      dmemAck = 1'b1;
      dmemReadData = dat[i];
      tick();
      tests++; if (memoryOut_writeback !== exp[i]) begin fails++; $display("FAIL ext%0d got %h want %h", i, memoryOut_writeback, exp[i]); end
    end
    idle_in();
    tick();
  endtask

  task automatic test_wait_load();
    logic [2:0]  f3  [2];
    logic [31:0] exp [2];
    f3  = '{3'b000, 3'b100};
    exp = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int k = 0; k < 2; k++) begin
      load(32'h0000_0203, f3[k], 5'd4);
      dmemAck = 1'b0;
      dmemReadData = 32'h80FF_FF7F;
      for (int i = 0; i < 3; i++) begin
        #1;
        tests++; if (stall_memory !== 1'b1 || dmemReq !== 1'b1) begin fails++; $display("FAIL wait%0d_%0d got stall=%b req=%b want 1 1", k, i, stall_memory, dmemReq); end
        tick();
        tests++; if (valid_writeback !== 1'b0) begin fails++; $display("FAIL wait_bubble%0d_%0d got %b want 0", k, i, valid_writeback); end
      end
      dmemAck = 1'b1;
      #1;
      tests++; if (stall_memory !== 1'b0) begin fails++; $display("FAIL wait_ack%0d got %b want 0", k, stall_memory); end
      tick();
      idle_in();
      tests++; if (valid_writeback !== 1'b1 || memoryOut_writeback !== exp[k]) begin fails++; $display("FAIL wait_done%0d got v=%b d=%h want v=1 d=%h", k, valid_writeback, memoryOut_writeback, exp[k]); end
    end
  endtask

  task automatic test_store();
    valid_memory = 1'b1;
    memoryWriteEnable_memory = 1'b1;
    rdSource_memory = 1'b0;
    rdWriteEnable_memory = 1'b0;
    aluResult_memory = 32'h0000_0402;
    memByteMask_memory = 4'b1100;
    memDataToWrite_memory = 32'hABCD_0000;
    funct3_memory = 3'b001;
    dmemAck = 1'b0;
    #1;
    tests++; if (dmemWrite !== 1'b1 || dmemByteMask !== 4'hC) begin fails++; $display("FAIL sh_c1 got w=%b m=%h want w=1 m=c", dmemWrite, dmemByteMask); end
    tests++; if (dmemWriteData !== 32'hABCD_0000 || dmemAddr !== 30'h100) begin fails++; $display("FAIL sh_bus got d=%h a=%h want abcd0000 100", dmemWriteData, dmemAddr); end
    tests++; if (stall_memory !== 1'b1) begin fails++; $display("FAIL sh_stall got %b want 1", stall_memory); end
    tick();
    tests++; if (valid_writeback !== 1'b0) begin fails++; $display("FAIL sh_bubble got %b want 0", valid_writeback); end
    dmemAck = 1'b1;
    #1;
    tests++; if (dmemWrite !== 1'b1 || dmemByteMask !== 4'hC || stall_memory !== 1'b0) begin fails++; $display("FAIL sh_c2 got w=%b m=%h s=%b want 1 c 0", dmemWrite, dmemByteMask, stall_memory); end
    tick();
    tests++; if (valid_writeback !== 1'b1 || rdWriteEnable_writeback !== 1'b0) begin fails++; $display("FAIL sh_wb got v=%b we=%b want 1 0", valid_writeback, rdWriteEnable_writeback); end
    tests++; if (memoryOut_writeback !== 32'h0000_0080) begin fails++; $display("FAIL sh_hold got %h want 00000080", memoryOut_writeback); end
    // Both flags set: treated as a store, load data not captured
    rdSource_memory = 1'b1;
    funct3_memory = 3'b010;
    aluResult_memory = 32'h0000_0400;
    dmemReadData = 32'h1111_1111;
    #1;
    tests++; if (dmemWrite !== 1'b1 || dmemReq !== 1'b1) begin fails++; $display("FAIL both_bus got w=%b r=%b want 1 1", dmemWrite, dmemReq); end
    tick();
    idle_in();
    tests++; if (memoryOut_writeback !== 32'h0000_0080) begin fails++; $display("FAIL both_hold got %h want 00000080", memoryOut_writeback); end
  endtask

  task automatic test_timeout();
    load(32'h0000_0500, 3'b010, 5'd6);
    dmemAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (stall_memory !== 1'b1 || busError !== 1'b0) begin fails++; $display("FAIL to_wait%0d got s=%b e=%b want 1 0", i, stall_memory, busError); end
      tick();
    end
    #1;
    tests++; if (busError !== 1'b1 || stall_memory !== 1'b0) begin fails++; $display("FAIL to_abort got e=%b s=%b want 1 0", busError, stall_memory); end
    tick();
    tests++; if (valid_writeback !== 1'b0 || rdWriteEnable_writeback !== 1'b0) begin fails++; $display("FAIL to_bubble got v=%b we=%b want 0 0", valid_writeback, rdWriteEnable_writeback); end
    tests++; if (busError !== 1'b0) begin fails++; $display("FAIL to_pulse got %b want 0", busError); end
    dmemAck = 1'b1;
    dmemReadData = 32'h5A5A_5A5A;
    tick();
    idle_in();
    tests++; if (valid_writeback !== 1'b1 || memoryOut_writeback !== 32'h5A5A_5A5A) begin fails++; $display("FAIL to_retry got v=%b d=%h want 1 5a5a5a5a", valid_writeback, memoryOut_writeback); end
  endtask

  task automatic test_back_to_back();
    valid_memory = 1'b1;
    rdWriteEnable_memory = 1'b1;
    rdAddr_memory = 5'd7;
    aluResult_memory = 32'h1234_5678;
    #1;
    tests++; if (dmemReq !== 1'b0 || stall_memory !== 1'b0) begin fails++; $display("FAIL alu_bus got r=%b s=%b want 0 0", dmemReq, stall_memory); end
    tick();
    valid_memory = 1'b0;
    tests++; if (aluResult_writeback !== 32'h1234_5678 || valid_writeback !== 1'b1) begin fails++; $display("FAIL alu_wb got a=%h v=%b want 12345678 1", aluResult_writeback, valid_writeback); end
    tests++; if (rdAddr_writeback !== 5'd7 || rdSource_writeback !== 1'b0) begin fails++; $display("FAIL alu_rd got rd=%0d src=%b want 7 0", rdAddr_writeback, rdSource_writeback); end
    tick();
    idle_in();
    tests++; if (valid_writeback !== 1'b0) begin fails++; $display("FAIL alu_bubble got %b want 0", valid_writeback); end
  endtask

  task automatic test_misalign();
    load(32'h0000_0601, 3'b010, 5'd8);
    dmemAck = 1'b1;
    dmemReadData = 32'h7777_7777;
    #1;
`ifdef JZJPCC_MEM_MISALIGN_CHECK_EN
    tests++; if (misalignedFault !== 1'b1 || dmemReq !== 1'b0 || stall_memory !== 1'b0) begin fails++; $display("FAIL mis_on got f=%b r=%b s=%b want 1 0 0", misalignedFault, dmemReq, stall_memory); end
    tick();
    idle_in();
    tests++; if (valid_writeback !== 1'b0) begin fails++; $display("FAIL mis_bubble got %b want 0", valid_writeback); end
    #1;
    tests++; if (misalignedFault !== 1'b0) begin fails++; $display("FAIL mis_pulse got %b want 0", misalignedFault); end
`else
    tests++; if (misalignedFault !== 1'b0 || dmemReq !== 1'b1) begin fails++; $display("FAIL mis_off got f=%b r=%b want 0 1", misalignedFault, dmemReq); end
    tick();
    idle_in();
    tests++; if (valid_writeback !== 1'b1 || memoryOut_writeback !== 32'h7777_7777) begin fails++; $display("FAIL mis_off_wb got v=%b d=%h want 1 77777777", valid_writeback, memoryOut_writeback); end
`endif
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    test_lw();
    test_reset();
    test_load_ext();
    test_wait_load();
    test_store();
    test_timeout();
    test_back_to_back();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
